osu_gen_data_mc: RTL
====================

# osu_gen_data_mc

Parametrised, multi-channel OSU test-traffic generator for the OSU datapath. It emits framed OSUs on a wide byte bus under valid/ready backpressure. Each OSU is one header beat followed by payload beats. Channels are served round-robin at OSU boundaries. Each channel keeps its own payload byte counter and OSU sequence number, so downstream deframers and checkers can verify ordering and content per channel.

## Interface
- BYTES_PER_BEAT, 48, bus width in bytes; out_data is 8*BYTES_PER_BEAT bits.
- BEATS_PER_OSU, 4, beats per OSU; must be at least 2.
- HDR_BYTES, 7, header bytes at the start of beat 0; must be at least 4 and less than BYTES_PER_BEAT.
- NUM_CH, 4, number of logical channels, at least 1; localparam CH_W = max(1, clog2(NUM_CH)).

Ports:
- clk  in  1  single clock; all logic on its rising edge.
- rst  in  1  synchronous, active-high reset.
- enable  in  1  permits loading new beats.
- ch_enable  in  NUM_CH  per-channel participation mask.
- out_ready  in  1  downstream ready.
- out_valid  out  1  beat valid.
- out_data  out  8*BYTES_PER_BEAT  beat; byte k occupies bits [8*BYTES_PER_BEAT-1-8k -: 8], so byte 0 is the MSB byte.
- out_sof  out  1  high on beat 0 (header beat).
- out_eof  out  1  high on beat BEATS_PER_OSU-1.
- out_ch  out  CH_W  channel of the current beat.
- osu_done_cnt  out  16  count of completed OSUs (eof accepted), wraps mod 2^16.

## Operation
- Header bytes in beat 0:
  - byte 0 = 0xA5.
  - byte 1 = channel id (zero-extended to 8 bits).
  - bytes 2..3 = 16-bit channel sequence number, big-endian.
  - bytes 4..HDR_BYTES-1 = 0x00.
  - bytes HDR_BYTES.. = payload.
- Payload bytes: each byte equals the low 8 bits of that channel's byte counter; the counter increments once per payload byte and wraps 0xFF -> 0x00, including inside a beat.
- Counter advance on acceptance of a beat: header beat +(BYTES_PER_BEAT-HDR_BYTES); payload beat +BYTES_PER_BEAT; all mod 256.
- Payload per OSU = BEATS_PER_OSU*BYTES_PER_BEAT-HDR_BYTES (185 by default).
- Per-channel sequence number increments by 1 when that channel's eof beat is accepted; wraps 0xFFFF -> 0x0000.
- State: beat index 0..BEATS_PER_OSU-1, current channel, last-served pointer.
- Loading beat 0 selects the first channel with ch_enable set, searching upward from last-served+1 modulo NUM_CH.
- If no channel is enabled, nothing is loaded and out_valid stays low.
- An OSU in progress always completes on its channel even if that channel's ch_enable bit drops.
- ch_enable changes only affect the next arbitration.

## Timing
- Reset values:
  - out_valid=0, out_sof=0, out_eof=0, out_ch=0, out_data=0, osu_done_cnt=0.
  - All byte counters=0, all sequence numbers=0.
  - Beat index=0; last-served=NUM_CH-1, so channel 0 is picked first.
- Output register loads when enable=1 and (out_valid=0 or out_ready=1), subject to a channel being available for beat 0.
- Latency: the first beat is valid in the cycle after the first load condition holds.
- Throughput is 1 beat per cycle with no bubble between beats or between OSUs.
- Handshake: once out_valid=1, out_data, out_sof, out_eof and out_ch are held stable until out_valid and out_ready are both high. out_valid never drops without acceptance, except on rst.
- enable=0: the current valid beat stays presented until accepted, then out_valid falls. The position within the OSU is retained, and with enable=1 it resumes at the next beat, never restarting the OSU.
- All counter, sequence, pointer and osu_done_cnt updates occur on the accepting edge only.
- rst mid-OSU: the next cycle shows out_valid=0 with all state at reset values. The partial OSU is abandoned; the next OSU starts at channel 0, sequence 0, payload 0x00.

## Test plan
- Defaults, ch_enable=0001, out_ready=1, enable=1:
  - beat 0 = A5 00 00 00 00 00 00 then payload 00..28; beats 1..3 carry payload 29..B8, eof on beat 3.
  - The second OSU header has sequence 0001 and payload starting B9; the byte counter wraps FF->00 at payload byte 71 of that OSU.
  - osu_done_cnt=1 after the first eof.
- ch_enable=1111 -> out_ch per OSU is 0,1,2,3,0. Each channel's first OSU has sequence 0000 and payload starting 00; channel 0's second OSU has sequence 0001 and payload starting B9.
- out_ready low for 3 cycles during beat 2 -> out_data and flags stable throughout; no beat skipped or duplicated.
- enable dropped during beat 1 with out_ready=1 -> beat 1 accepted, then out_valid=0. With enable=1 again, beat 2 follows with correct payload continuation and sof=0.
- ch_enable=0101, channel 2 disabled mid-OSU -> channel 2's OSU completes; subsequent OSUs only on channel 0. With ch_enable=0000, out_valid stays low after the current eof.
- rst asserted while out_valid=1 mid-OSU -> out_valid=0 the next cycle. The first post-reset beat is a header for channel 0 with sequence 0000 and payload 00; osu_done_cnt=0.

Source files
------------

// File: rtl/osu_gen_data_mc.sv
// rtl/osu_gen_data_mc.sv - multi-channel framed OSU test-traffic generator
module osu_gen_data_mc #(
    parameter int BYTES_PER_BEAT = 48,
    parameter int BEATS_PER_OSU  = 4,
    parameter int HDR_BYTES      = 7,
    parameter int NUM_CH         = 4,
    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        enable,
    input  logic [NUM_CH-1:0]           ch_enable,
    input  logic                        out_ready,
    output logic                        out_valid,
    output logic [8*BYTES_PER_BEAT-1:0] out_data,
    output logic                        out_sof,
    output logic                        out_eof,
    output logic [CH_W-1:0]             out_ch,
    output logic [15:0]                 osu_done_cnt
);

    localparam int DW   = 8 * BYTES_PER_BEAT;
    localparam int BI_W = (BEATS_PER_OSU > 1) ? $clog2(BEATS_PER_OSU) : 1;
    localparam logic [7:0]      HDR_ADV   = 8'(BYTES_PER_BEAT - HDR_BYTES);
    localparam logic [7:0]      BEAT_ADV  = 8'(BYTES_PER_BEAT);
    localparam logic [BI_W-1:0] LAST_BEAT = BI_W'(BEATS_PER_OSU - 1);

    logic [7:0]      r_cnt [NUM_CH];
    logic [15:0]     r_seq [NUM_CH];
    logic [BI_W-1:0] r_beat_idx;
    logic [CH_W-1:0] r_cur_ch;
    logic [CH_W-1:0] r_last_ch;
    logic            r_valid;
    logic            r_sof;
    logic            r_eof;
    logic [DW-1:0]   r_data;
    logic [CH_W-1:0] r_ch;
    logic [15:0]     r_done;

    logic            w_accept;
    logic            w_load;
    logic            w_ld_sof;
    logic            w_any_en;
    logic [CH_W-1:0] w_arb_ch;
    logic [CH_W-1:0] w_ld_ch;
    logic            w_byp;
    logic [7:0]      w_base_cnt;
    logic [15:0]     w_base_seq;
    logic [DW-1:0]   w_data;
    int              w_arb_idx;

    assign w_accept = r_valid & out_ready;
    assign w_ld_sof = (r_beat_idx == '0);
    assign w_ld_ch  = w_ld_sof ? w_arb_ch : r_cur_ch;
    assign w_load   = enable & (~r_valid | out_ready) & (~w_ld_sof | w_any_en);

    // Descending scan so the nearest enabled channel after last-served wins.
    always_comb begin
        w_arb_ch  = '0;
        w_any_en  = 1'b0;
        w_arb_idx = 0;
        for (int i = NUM_CH; i >= 1; i--) begin
            w_arb_idx = (int'(r_last_ch) + i) % NUM_CH;
            if (ch_enable[CH_W'(w_arb_idx)]) begin
                w_arb_ch = CH_W'(w_arb_idx);
                w_any_en = 1'b1;
            end
        end
    end

    // Counters advance only on acceptance, so a beat loaded on the same edge
    // must see the advance of the beat leaving the output register.
    assign w_byp      = w_accept & (r_ch == w_ld_ch);
    assign w_base_cnt = r_cnt[w_ld_ch] + (w_byp ? (r_sof ? HDR_ADV : BEAT_ADV) : 8'd0);
    assign w_base_seq = r_seq[w_ld_ch] + ((w_byp && r_eof) ? 16'd1 : 16'd0);

    always_comb begin
        w_data = '0;
        for (int k = 0; k < BYTES_PER_BEAT; k++) begin
            if (w_ld_sof && k < HDR_BYTES) begin
                case (k)
                    0:       w_data[DW-1-8*k -: 8] = 8'hA5;
                    1:       w_data[DW-1-8*k -: 8] = 8'(w_ld_ch);
                    2:       w_data[DW-1-8*k -: 8] = w_base_seq[15:8];
                    3:       w_data[DW-1-8*k -: 8] = w_base_seq[7:0];
                    default: w_data[DW-1-8*k -: 8] = 8'h00;
                endcase
            end else begin
                w_data[DW-1-8*k -: 8] = w_base_cnt + 8'(k - (w_ld_sof ? HDR_BYTES : 0));
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < NUM_CH; c++) begin
                r_cnt[c] <= 8'd0;
                r_seq[c] <= 16'd0;
            end
            r_beat_idx <= '0;
            r_cur_ch   <= '0;
            r_last_ch  <= CH_W'(NUM_CH - 1);
            r_valid    <= 1'b0;
            r_sof      <= 1'b0;
            r_eof      <= 1'b0;
            r_data     <= '0;
            r_ch       <= '0;
            r_done     <= 16'd0;
        end else begin
            if (w_accept) begin
                r_cnt[r_ch] <= r_cnt[r_ch] + (r_sof ? HDR_ADV : BEAT_ADV);
                if (r_sof) begin
                    r_last_ch <= r_ch;
                end
                if (r_eof) begin
                    r_seq[r_ch] <= r_seq[r_ch] + 16'd1;
                    r_done      <= r_done + 16'd1;
                end
            end
            if (w_load) begin
                r_valid    <= 1'b1;
                r_data     <= w_data;
                r_sof      <= w_ld_sof;
                r_eof      <= (r_beat_idx == LAST_BEAT);
                r_ch       <= w_ld_ch;
                r_cur_ch   <= w_ld_ch;
                r_beat_idx <= (r_beat_idx == LAST_BEAT) ? '0 : r_beat_idx + 1'b1;
            end else if (w_accept) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign out_valid    = r_valid;
    assign out_data     = r_data;
    assign out_sof      = r_sof;
    assign out_eof      = r_eof;
    assign out_ch       = r_ch;
    assign osu_done_cnt = r_done;

endmodule
